// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL        = 1'b1;
  localparam logic UART_START_LEVEL       = 1'b0;
  localparam int   UART_DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: start, DATA_BITS data bits LSB first, optional even
// parity (UART_TX_PARITY_EN), STOP_BITS stop bits; paced by an external baud tick.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DEFAULT_DATA_BITS,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  output logic                 baud_clr,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]     bitcnt, bitcnt_nxt;
  logic                 txd_q, txd_nxt;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_nxt;
`endif

  assign accept   = (state == IDLE) && valid;
  assign baud_clr = accept;
  assign ready    = (state == IDLE);
  assign busy     = (state != IDLE) || accept;
  assign txd      = txd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      txd_q  <= UART_IDLE_LEVEL;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      txd_q  <= txd_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_nxt;
  end
`endif

  // txd_nxt is the line level of the state being entered, so txd stays registered.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    txd_nxt    = txd_q;
`ifdef UART_TX_PARITY_EN
    par_nxt    = par_q;
`endif
    case (state)
      IDLE: begin
        txd_nxt = UART_IDLE_LEVEL;
        if (valid) begin
          shreg_nxt  = data_in;
          bitcnt_nxt = '0;
          state_nxt  = START;
          txd_nxt    = UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
          par_nxt    = ^data_in;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          txd_nxt   = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt = shreg >> 1;
          if (bitcnt == LAST_DATA) begin
            bitcnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt  = PARITY;
            txd_nxt    = par_q;
`else
            state_nxt  = STOP;
            txd_nxt    = UART_IDLE_LEVEL;
`endif
          end else begin
            bitcnt_nxt = bitcnt + CNT_W'(1);
            txd_nxt    = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          txd_nxt   = UART_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        txd_nxt = UART_IDLE_LEVEL;
        if (tick) begin
          if (bitcnt == LAST_STOP) begin
            bitcnt_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            bitcnt_nxt = bitcnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule
